// File: rtl/debug_seg_driver.sv
// Avalon-MM debug display: six active-low hex digits plus ten LEDs, with blank and blink masks.
// Optional blink logic is built only when DEBUG_SEG_BLINK_EN is defined.
module debug_seg_driver #(
    parameter int unsigned BLINK_DIV        = 25000000,
    parameter bit          RESET_EN_DISPLAY = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [3:0]  avs_byteenable,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [41:0] seg_out,
    output logic [9:0]  led_out
);

    logic [23:0] value;
    logic [5:0]  blank_mask;
    logic        enable;
    logic [9:0]  leds;
    logic        phase;
    logic [5:0]  blink_active;
    logic        ctrl_write;
    logic [31:0] rd_mux;
    logic [41:0] seg_next;

    assign ctrl_write = avs_write && (avs_address == 2'd1);

`ifdef DEBUG_SEG_BLINK_EN
    localparam int unsigned CntW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BLINK_DIV - 1);

    logic [5:0]      blink_mask;
    logic [CntW-1:0] blink_cnt;

    // A CTRL write restarts the blink cycle so software sees a deterministic phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (ctrl_write) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == CntLast) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_mask <= '0;
        end else if (ctrl_write && avs_byteenable[1]) begin
            blink_mask <= avs_writedata[13:8];
        end
    end

    assign blink_active = blink_mask & {6{phase}};
`else
    assign phase        = 1'b0;
    assign blink_active = '0;
`endif

    logic unused_bits;
    assign unused_bits = ^{avs_writedata[31:24], avs_byteenable[3], ctrl_write};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value      <= '0;
            blank_mask <= '0;
            enable     <= RESET_EN_DISPLAY;
            leds       <= '0;
        end else if (avs_write) begin
            unique case (avs_address)
                2'd0: begin
                    if (avs_byteenable[0]) value[7:0]   <= avs_writedata[7:0];
                    if (avs_byteenable[1]) value[15:8]  <= avs_writedata[15:8];
                    if (avs_byteenable[2]) value[23:16] <= avs_writedata[23:16];
                end
                2'd1: begin
                    if (avs_byteenable[0]) blank_mask <= avs_writedata[5:0];
                    if (avs_byteenable[2]) enable     <= avs_writedata[16];
                end
                2'd2: begin
                    if (avs_byteenable[0]) leds[7:0] <= avs_writedata[7:0];
                    if (avs_byteenable[1]) leds[9:8] <= avs_writedata[9:8];
                end
                2'd3: value <= value + avs_writedata[23:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (avs_address)
            2'd0: rd_mux[23:0] = value;
            2'd1: begin
                rd_mux[5:0] = blank_mask;
`ifdef DEBUG_SEG_BLINK_EN
                rd_mux[13:8] = blink_mask;
`endif
                rd_mux[16] = enable;
            end
            2'd2: rd_mux[9:0] = leds;
            2'd3: rd_mux = {value, 7'b0, phase};
            default: ;
        endcase
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        seg_next = '1;
        for (int k = 0; k < 6; k++) begin
            if (enable && !blank_mask[k] && !blink_active[k]) begin
                seg_next[7*k +: 7] = hex7(value[4*k +: 4]);
            end
        end
    end

    // Read data and display drive are registered from pre-write state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
            seg_out      <= '1;
            led_out      <= '0;
        end else begin
            if (avs_read) avs_readdata <= rd_mux;
            seg_out <= seg_next;
            led_out <= leds;
        end
    end

endmodule

// File: tb/tb_debug_seg_driver.sv
// Directed self-checking bench for debug_seg_driver with a short blink period.
module tb_debug_seg_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [41:0] seg_out;
    logic [9:0]  led_out;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [41:0] SegBlank = {42{1'b1}};

    always #5 clk = ~clk;

    debug_seg_driver #(
        .BLINK_DIV(4),
        .RESET_EN_DISPLAY(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_byteenable(avs_byteenable),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .seg_out(seg_out),
        .led_out(led_out)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [41:0] segs(input logic [6:0] d5, input logic [6:0] d4,
                                         input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data,
                             input logic [3:0] be);
        @(negedge clk);
        avs_address    = addr;
        avs_writedata  = data;
        avs_byteenable = be;
        avs_write      = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        data     = avs_readdata;
    endtask

    logic [31:0] rd;
    logic [41:0] exp_seg;

    initial begin
        reset_n        = 1'b0;
        avs_address    = '0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_byteenable = '0;
        avs_writedata  = '0;

        #23;
        check_eq("reset_seg", seg_out, SegBlank);
        check_eq("reset_led", led_out, 10'h0);
        check_eq("reset_rdata", avs_readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("first_edge_zeros", seg_out, {6{7'h40}});
        bus_read(2'd1, rd);
        check_eq("ctrl_reset", rd, 32'h0001_0000);

        // Partial byte-lane write, then latency and decode.
        bus_write(2'd0, 32'h00AB_C123, 4'b0011);
        check_eq("value_latency", seg_out, {6{7'h40}});
        @(negedge clk);
        check_eq("value_decode", seg_out, segs(7'h40, 7'h40, 7'h46, 7'h79, 7'h24, 7'h30));
        bus_read(2'd0, rd);
        check_eq("value_readback", rd, 32'h0000_C123);

        // Read and write together return the old value.
        @(negedge clk);
        avs_address    = 2'd0;
        avs_writedata  = 32'h0011_1111;
        avs_byteenable = 4'hF;
        avs_write      = 1'b1;
        avs_read       = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        avs_read  = 1'b0;
        check_eq("rd_wr_same_cycle", avs_readdata, 32'h0000_C123);
        bus_read(2'd0, rd);
        check_eq("value_after_rw", rd, 32'h0011_1111);

        // ADD wraps modulo 2^24 and ignores byteenable.
        bus_write(2'd0, 32'h00FF_FFFE, 4'b0111);
        bus_write(2'd3, 32'hAA00_0005, 4'b0000);
        bus_read(2'd3, rd);
        check_eq("add_wrap_status", {rd[31:1], 1'b0}, 32'h0000_0300);
        bus_read(2'd0, rd);
        check_eq("add_wrap_value", rd, 32'h0000_0003);

        // Blink digit 0: 4 cycles visible, 4 blank, then visible again.
        bus_write(2'd1, 32'h0001_0100, 4'hF);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            exp_seg = segs(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h30);
`ifdef DEBUG_SEG_BLINK_EN
            if (i >= 5 && i <= 8) exp_seg[6:0] = 7'h7F;
`endif
            check_eq($sformatf("blink_cyc%0d", i), seg_out, exp_seg);
        end
        bus_read(2'd1, rd);
`ifdef DEBUG_SEG_BLINK_EN
        check_eq("ctrl_blink_rb", rd, 32'h0001_0100);
`else
        check_eq("ctrl_blink_rb", rd, 32'h0001_0000);
`endif

        // CTRL rewrite while blanked restarts at phase 0.
        bus_write(2'd1, 32'h0001_0100, 4'hF);
        for (int i = 1; i <= 6; i++) @(negedge clk);
        bus_write(2'd1, 32'h0001_0100, 4'hF);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            exp_seg = segs(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h30);
`ifdef DEBUG_SEG_BLINK_EN
            if (i == 5) exp_seg[6:0] = 7'h7F;
`endif
            check_eq($sformatf("restart_cyc%0d", i), seg_out, exp_seg);
        end

        // Blank mask on digit 1.
        bus_write(2'd1, 32'h0001_0002, 4'hF);
        @(negedge clk);
        check_eq("blank_mask", seg_out, segs(7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h30));

        // Display off; LEDs are independent of enable.
        bus_write(2'd1, 32'h0000_0000, 4'hF);
        @(negedge clk);
        check_eq("disable_seg", seg_out, SegBlank);
        bus_write(2'd2, 32'h0000_03FF, 4'b0011);
        check_eq("led_latency", led_out, 10'h000);
        @(negedge clk);
        check_eq("led_on", led_out, 10'h3FF);
        bus_write(2'd2, 32'h0000_0000, 4'b0001);
        bus_read(2'd2, rd);
        check_eq("led_lane", rd, 32'h0000_0300);

        // Asynchronous reset mid-blink with a read pending.
        bus_write(2'd1, 32'h0001_0100, 4'hF);
        repeat (5) @(negedge clk);
        check_eq("pre_reset_seg", seg_out[41:7], {5{7'h40}});
        avs_address = 2'd0;
        avs_read    = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rdata", avs_readdata, 32'h0);
        check_eq("async_seg", seg_out, SegBlank);
        check_eq("async_led", led_out, 10'h0);
        @(negedge clk);
        avs_read = 1'b0;
        check_eq("held_rdata", avs_readdata, 32'h0);
        reset_n = 1'b1;
        bus_read(2'd1, rd);
        check_eq("post_reset_ctrl", rd, 32'h0001_0000);
        bus_read(2'd0, rd);
        check_eq("post_reset_value", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
